exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Issue/completion controller for the execute stage, which contains a single-cycle ALU/branch path and a multi-cycle FPU that signals `fin` when it is done.
- Accepts one instruction at a time from decode over a valid/ready handshake.
- Pulses the FPU start and waits for `fin`, with a timeout guard.
- Presents the completed op to the memory stage over a second valid/ready handshake.
- Handles pipeline flush on branch/jump miss and counts FPU stall cycles.

Parameters:
- FPU_TIMEOUT, 64: maximum FPU wait cycles before a forced completion with error.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  sequencer can accept this cycle.
- issue_aluorfpu  in  1  0 = ALU/branch op, 1 = FPU op.
- issue_rd  in  6  destination register.
- issue_regwrite  in  1  writes a register.
- issue_memread  in  1  is a load.
- flush  in  1  branch/jump miss; kill everything in flight.
- fpu_start  out  1  one-cycle FPU launch pulse.
- fpu_fin  in  1  FPU result valid.
- out_valid  out  1  completed op available.
- out_ready  in  1  downstream accepts.
- out_rd  out  6  captured rd.
- out_regwrite  out  1  captured regwrite.
- out_memread  out  1  captured memread.
- out_fpu  out  1  captured aluorfpu; selects the FPU result.
- out_err  out  1  FPU timed out; the result is garbage.
- busy  out  1  state != IDLE.
- stall_cnt  out  CNT_W  count of cycles spent in FPU_WAIT.

Behaviour:
- States: IDLE, FPU_WAIT, DONE, DRAIN. Encoding is free.

Reset:
- Applies on any rising clk edge while rst=1, in any state, including mid-FPU.
- state=IDLE; out_valid, out_err, fpu_start, out_* fields = 0; stall_cnt = 0; internal wait counter = 0.
- An FPU fin that arrives after a reset is ignored.

issue_ready:
- Equals (state==IDLE) or (state==DONE and out_ready), and is forced to 0 whenever flush=1 or rst=1.
- Accept = issue_valid & issue_ready.
- On accept, register rd, regwrite, memread and aluorfpu into the out_* fields.

ALU op accepted in cycle t:
- Next state DONE; out_valid=1 in cycle t+1.
- Latency is 1.

FPU op accepted in cycle t:
- Next state FPU_WAIT; fpu_start=1 in cycle t+1 only.
- The wait counter clears to 0 at accept.
- In FPU_WAIT, fpu_fin is sampled from cycle t+2 onward; fpu_fin in the start cycle is ignored.
- fpu_fin=1 sampled in cycle k → DONE, with out_valid=1 in cycle k+1 and out_err=0.
- Each FPU_WAIT cycle increments the wait counter.
- If the counter reaches FPU_TIMEOUT-1 with no fin → DONE with out_err=1.

DONE:
- Hold out_valid and all out_* fields stable until out_ready.
- On out_ready with no new accept → IDLE, with out_valid=0 next cycle.
- On out_ready with a simultaneous accept → go directly to DONE (ALU) or FPU_WAIT (FPU), giving back-to-back throughput of 1 op/cycle for ALU ops.

Flush (highest priority after rst):
- From IDLE or DONE → IDLE; out_valid drops next cycle and the held op is discarded even if out_ready=1 in the same cycle.
- From FPU_WAIT → DRAIN, unless fpu_fin is valid that same cycle, in which case → IDLE.
- DRAIN: issue_ready=0, out_valid=0. Leave on fpu_fin or on timeout (counter continues) → IDLE, with no output produced.
- A flush while already in DRAIN has no further effect.

Other rules:
- Spurious fpu_fin in IDLE, DONE or the start cycle is ignored.
- stall_cnt increments by 1 every cycle state==FPU_WAIT, wraps modulo 2^CNT_W, and is not cleared by flush.
- Exactly one op is ever in flight; fpu_start is never asserted outside the first FPU_WAIT cycle.

Test Plan:
- ALU back-to-back: issue_valid=1 with aluorfpu=0, rd=3,4,5 on consecutive cycles, out_ready=1 → out_valid high from cycle 1 onward; out_rd = 3,4,5 in cycles 1,2,3; issue_ready stays 1.
- FPU normal: FPU op rd=7 accepted at t=0, fpu_fin pulsed at t=4 → fpu_start only at t=1; out_valid at t=5 with out_rd=7, out_fpu=1, out_err=0; stall_cnt=4 (t=1..4).
- Backpressure: ALU op completes with out_ready=0 for 3 cycles, issue_valid held → issue_ready=0 and out_* stable for 3 cycles; on out_ready=1, the next op is accepted in the same cycle.
- Timeout: FPU_TIMEOUT=8, FPU op with no fin → DONE entered after 8 FPU_WAIT cycles; out_err=1; a later fin is ignored.
- Flush during FPU: flush at t=2 of FPU_WAIT, fin at t=6 → DRAIN from t=3 to t=6; out_valid never asserts; issue_ready=1 at t=7.
- Reset mid-op: rst=1 during FPU_WAIT, then fin arrives one cycle after reset release → all outputs 0, stall_cnt=0, state IDLE, no out_valid.

Source files
------------

// File: rtl/exec_sequencer.sv
// Execute-stage issue/completion sequencer.
// It accepts one op from decode at a time. ALU/branch ops finish in one cycle.
// FPU ops launch the multi-cycle FPU and wait for fin, with a timeout guard.
// The completed op is held for the memory stage until it is taken.
// A flush kills the op in flight. If the FPU is still busy, the sequencer drains it first.
module exec_sequencer #(
  parameter int FPU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_aluorfpu,
  input  logic [5:0]       issue_rd,
  input  logic             issue_regwrite,
  input  logic             issue_memread,
  input  logic             flush,
  output logic             fpu_start,
  input  logic             fpu_fin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_rd,
  output logic             out_regwrite,
  output logic             out_memread,
  output logic             out_fpu,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The wait counter only ever needs to reach FPU_TIMEOUT-1.
  localparam int WCNT_W = (FPU_TIMEOUT > 2) ? $clog2(FPU_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(FPU_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FPU_WAIT = 2'd1,
    S_DONE     = 2'd2,
    S_DRAIN    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              fpu_start_q, fpu_start_d;
  logic [5:0]        rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q, memread_d;
  logic              fpu_q, fpu_d;
  logic              err_q, err_d;

  logic accept;
  logic fin_ok;
  logic timeout;

  assign accept = issue_valid & issue_ready;
  // fin is ignored in the launch cycle. Outside FPU_WAIT/DRAIN, the state logic ignores it.
  assign fin_ok  = fpu_fin & ~fpu_start_q;
  assign timeout = (wcnt_q == TMO_LAST);

  // State register; reset wins in any state, including mid-FPU.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush takes priority over completion and handoff.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = issue_aluorfpu ? S_FPU_WAIT : S_DONE;
      end
      S_FPU_WAIT: begin
        if (flush) begin
          // If the FPU has just finished or used up its budget, nothing remains to drain.
          state_d = (fin_ok || timeout) ? S_IDLE : S_DRAIN;
        end else if (fin_ok || timeout) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (accept) state_d = issue_aluorfpu ? S_FPU_WAIT : S_DONE;
          else        state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (fin_ok || timeout) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    issue_ready = 1'b0;
    out_valid   = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:  issue_ready = 1'b1;
      S_DONE: begin
        issue_ready = out_ready;
        out_valid   = 1'b1;
      end
      default: issue_ready = 1'b0;
    endcase
    if (flush || rst) issue_ready = 1'b0;
  end

  // Next values for the captured op fields, the FPU launch pulse, and the counters.
  always_comb begin
    fpu_start_d = accept & issue_aluorfpu;
    rd_d        = rd_q;
    regwrite_d  = regwrite_q;
    memread_d   = memread_q;
    fpu_d       = fpu_q;
    err_d       = err_q;
    wcnt_d      = wcnt_q;
    stall_d     = stall_q;
    if (accept) begin
      rd_d       = issue_rd;
      regwrite_d = issue_regwrite;
      memread_d  = issue_memread;
      fpu_d      = issue_aluorfpu;
      err_d      = 1'b0;
      wcnt_d     = '0;
    end else if (state_q == S_FPU_WAIT || state_q == S_DRAIN) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
    // Completion without a valid fin means the FPU timed out.
    if (state_q == S_FPU_WAIT && state_d == S_DONE && !fin_ok) err_d = 1'b1;
    // Stall counter wraps naturally, and flush does not clear it.
    if (state_q == S_FPU_WAIT) stall_d = stall_q + CNT_W'(1);
  end

  // Datapath and counter registers; all of them clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_start_q <= 1'b0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      fpu_q       <= 1'b0;
      err_q       <= 1'b0;
      wcnt_q      <= '0;
      stall_q     <= '0;
    end else begin
      fpu_start_q <= fpu_start_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      fpu_q       <= fpu_d;
      err_q       <= err_d;
      wcnt_q      <= wcnt_d;
      stall_q     <= stall_d;
    end
  end

  assign fpu_start    = fpu_start_q;
  assign out_rd       = rd_q;
  assign out_regwrite = regwrite_q;
  assign out_memread  = memread_q;
  assign out_fpu      = fpu_q;
  assign out_err      = err_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer (FPU_TIMEOUT=8).
// Inputs change 1ns after each rising edge. Outputs are checked 1ns later, in the same cycle.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_aluorfpu;
  logic [5:0]  issue_rd;
  logic        issue_regwrite;
  logic        issue_memread;
  logic        flush;
  logic        fpu_start;
  logic        fpu_fin;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_rd;
  logic        out_regwrite;
  logic        out_memread;
  logic        out_fpu;
  logic        out_err;
  logic        busy;
  logic [31:0] stall_cnt;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_stall = '0;

  exec_sequencer #(.FPU_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_aluorfpu(issue_aluorfpu), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
    .flush(flush), .fpu_start(fpu_start), .fpu_fin(fpu_fin),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_fpu(out_fpu), .out_err(out_err), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic fpu, input logic [5:0] rd, input logic rw, input logic mr);
    issue_valid = 1'b1; issue_aluorfpu = fpu; issue_rd = rd;
    issue_regwrite = rw; issue_memread = mr;
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_valid = 1'b0; issue_aluorfpu = 1'b0; issue_rd = '0;
    issue_regwrite = 1'b0; issue_memread = 1'b0; flush = 1'b0;
    fpu_fin = 1'b0; out_ready = 1'b0;
    tick(); tick(); #1;
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b expected 0", issue_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", out_valid); end
    n_chk++; if (fpu_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %0b expected 0", fpu_start); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_stall: got %0d expected 0", stall_cnt); end
    n_chk++; if ({out_rd, out_regwrite, out_memread, out_fpu, out_err} !== 10'd0) begin n_fail++; $display("FAIL rst_fields: got %0h expected 0", {out_rd, out_regwrite, out_memread, out_fpu, out_err}); end
    rst = 1'b0; #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b expected 1", issue_ready); end
  endtask

  task automatic test_alu_back_to_back();
    out_ready = 1'b1; issue(1'b0, 6'd3, 1'b1, 1'b0); #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_c0_ready: got %0b expected 1", issue_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_c0_valid: got %0b expected 0", out_valid); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c < 3) issue_rd = 6'(3 + c);
      else issue_valid = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_c%0d_valid: got %0b expected 1", c, out_valid); end
      n_chk++; if (out_rd !== 6'(2 + c)) begin n_fail++; $display("FAIL b2b_c%0d_rd: got %0d expected %0d", c, out_rd, 2 + c); end
      n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_c%0d_ready: got %0b expected 1", c, issue_ready); end
      n_chk++; if ({out_fpu, out_regwrite} !== 2'b01) begin n_fail++; $display("FAIL b2b_c%0d_flags: got %0b expected 01", c, {out_fpu, out_regwrite}); end
    end
    tick(); #1;
    n_chk++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL b2b_end_idle: got %0b expected 00", {out_valid, busy}); end
  endtask

  task automatic test_fpu_normal();
    out_ready = 1'b1; fpu_fin = 1'b1;            // spurious fin while IDLE
    issue(1'b1, 6'd7, 1'b1, 1'b0); #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL fpu_c0_ready: got %0b expected 1", issue_ready); end
    tick(); issue_valid = 1'b0; fpu_fin = 1'b1; #1;   // fin in start cycle is ignored
    n_chk++; if (fpu_start !== 1'b1) begin n_fail++; $display("FAIL fpu_c1_start: got %0b expected 1", fpu_start); end
    n_chk++; if ({busy, out_valid} !== 2'b10) begin n_fail++; $display("FAIL fpu_c1_state: got %0b expected 10", {busy, out_valid}); end
    tick(); fpu_fin = 1'b0; #1;
    n_chk++; if ({fpu_start, out_valid, issue_ready} !== 3'b000) begin n_fail++; $display("FAIL fpu_c2_outs: got %0b expected 000", {fpu_start, out_valid, issue_ready}); end
    tick();
    tick(); fpu_fin = 1'b1; #1;
    n_chk++; if ({fpu_start, out_valid} !== 2'b00) begin n_fail++; $display("FAIL fpu_c4_outs: got %0b expected 00", {fpu_start, out_valid}); end
    tick(); fpu_fin = 1'b0; #1;
    exp_stall = exp_stall + 32'd4;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fpu_c5_valid: got %0b expected 1", out_valid); end
    n_chk++; if ({out_rd, out_fpu, out_err} !== {6'd7, 1'b1, 1'b0}) begin n_fail++; $display("FAIL fpu_c5_fields: got %0h expected %0h", {out_rd, out_fpu, out_err}, {6'd7, 1'b1, 1'b0}); end
    n_chk++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL fpu_c5_stall: got %0d expected %0d", stall_cnt, exp_stall); end
    tick(); #1;
    n_chk++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL fpu_c6_idle: got %0b expected 00", {out_valid, busy}); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; issue(1'b0, 6'd10, 1'b0, 1'b1);
    tick(); issue_rd = 6'd11; issue_memread = 1'b0;   // next op held valid
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      #1;
      n_chk++; if ({out_valid, issue_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_c%0d_hs: got %0b expected 10", c, {out_valid, issue_ready}); end
      n_chk++; if ({out_rd, out_memread, out_regwrite} !== {6'd10, 1'b1, 1'b0}) begin n_fail++; $display("FAIL bp_c%0d_fields: got %0h expected %0h", c, {out_rd, out_memread, out_regwrite}, {6'd10, 1'b1, 1'b0}); end
    end
    tick(); out_ready = 1'b1; #1;
    n_chk++; if ({issue_ready, out_rd} !== {1'b1, 6'd10}) begin n_fail++; $display("FAIL bp_release: got %0h expected %0h", {issue_ready, out_rd}, {1'b1, 6'd10}); end
    tick(); issue_valid = 1'b0; #1;
    n_chk++; if ({out_valid, out_rd, out_memread} !== {1'b1, 6'd11, 1'b0}) begin n_fail++; $display("FAIL bp_next_op: got %0h expected %0h", {out_valid, out_rd, out_memread}, {1'b1, 6'd11, 1'b0}); end
    tick(); #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_timeout();
    out_ready = 1'b0; issue(1'b1, 6'd20, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      tick(); issue_valid = 1'b0; #1;
      n_chk++; if ({out_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL tmo_wait_c%0d: got %0b expected 01", c, {out_valid, busy}); end
    end
    exp_stall = exp_stall + 32'd8;
    tick(); fpu_fin = 1'b1; #1;                 // late fin while DONE
    n_chk++; if ({out_valid, out_err, out_fpu, out_rd} !== {1'b1, 1'b1, 1'b1, 6'd20}) begin n_fail++; $display("FAIL tmo_done: got %0h expected %0h", {out_valid, out_err, out_fpu, out_rd}, {1'b1, 1'b1, 1'b1, 6'd20}); end
    n_chk++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL tmo_stall: got %0d expected %0d", stall_cnt, exp_stall); end
    tick(); fpu_fin = 1'b0; out_ready = 1'b1; #1;
    n_chk++; if ({out_valid, out_err} !== 2'b11) begin n_fail++; $display("FAIL tmo_late_fin: got %0b expected 11", {out_valid, out_err}); end
    tick(); #1;
    n_chk++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL tmo_end_idle: got %0b expected 00", {out_valid, busy}); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1; issue(1'b1, 6'd30, 1'b1, 1'b0);
    tick(); issue_valid = 1'b0;
    tick(); flush = 1'b1; #1;
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL fl_c2_ready: got %0b expected 0", issue_ready); end
    exp_stall = exp_stall + 32'd2;
    for (int c = 3; c <= 6; c++) begin
      tick(); flush = 1'b0; issue(1'b0, 6'd31, 1'b0, 1'b0);
      if (c == 6) fpu_fin = 1'b1;
      #1;
      n_chk++; if ({busy, out_valid, issue_ready} !== 3'b100) begin n_fail++; $display("FAIL fl_drain_c%0d: got %0b expected 100", c, {busy, out_valid, issue_ready}); end
    end
    tick(); fpu_fin = 1'b0; #1;
    n_chk++; if ({issue_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL fl_c7_hs: got %0b expected 10", {issue_ready, out_valid}); end
    n_chk++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL fl_c7_stall: got %0d expected %0d", stall_cnt, exp_stall); end
    tick(); issue_valid = 1'b0; flush = 1'b1; #1;   // flush the held ALU op despite out_ready
    n_chk++; if ({out_valid, out_rd, out_err, out_fpu} !== {1'b1, 6'd31, 1'b0, 1'b0}) begin n_fail++; $display("FAIL fl_c8_op: got %0h expected %0h", {out_valid, out_rd, out_err, out_fpu}, {1'b1, 6'd31, 1'b0, 1'b0}); end
    tick(); flush = 1'b0; #1;
    n_chk++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL fl_c9_discard: got %0b expected 00", {out_valid, busy}); end
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1; issue(1'b1, 6'd40, 1'b1, 1'b1);
    tick(); issue_valid = 1'b0;
    tick();
    tick(); rst = 1'b1; #1;
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rm_rst_ready: got %0b expected 0", issue_ready); end
    tick(); rst = 1'b0; fpu_fin = 1'b1; #1;
    n_chk++; if ({fpu_start, out_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL rm_ctrl: got %0b expected 000", {fpu_start, out_valid, busy}); end
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rm_stall: got %0d expected 0", stall_cnt); end
    n_chk++; if ({out_rd, out_regwrite, out_memread, out_fpu, out_err} !== 10'd0) begin n_fail++; $display("FAIL rm_fields: got %0h expected 0", {out_rd, out_regwrite, out_memread, out_fpu, out_err}); end
    tick(); fpu_fin = 1'b0; #1;
    n_chk++; if ({out_valid, busy, issue_ready} !== 3'b001) begin n_fail++; $display("FAIL rm_after_fin: got %0b expected 001", {out_valid, busy, issue_ready}); end
    tick(); #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_late_valid: got %0b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    tick();
    test_alu_back_to_back();
    tick();
    test_fpu_normal();
    tick();
    test_backpressure();
    tick();
    test_timeout();
    tick();
    test_flush();
    tick();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
